// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM clock-divider controller.
// Holds the controller state encoding and the default widths/reset divisor.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESYNC,
    RUN,
    WAIT_BND
  } state_e;

  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned RST_DIV_DEF = 0;

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter mirroring the divider phase; emits a tick on the last
// clk_i cycle of each divided period. Ports: clk_i, rst_ni, clear_i,
// en_i, divisor_i -> tick_o.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [DW-1:0] divisor_i,
  output logic          tick_o
);

  logic [DW:0] pcnt_q;
  logic [DW:0] limit;
  logic        at_lim;

  // Divided period is 2*D cycles; D=0 is bypass, so the limit is 0.
  assign limit  = (divisor_i == '0) ? '0
                : {divisor_i, 1'b0} - {{DW{1'b0}}, 1'b1};
  assign at_lim = (pcnt_q == limit);
  assign tick_o = en_i && at_lim;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
    end else if (clear_i) begin
      pcnt_q <= '0;
    end else if (en_i) begin
      pcnt_q <= at_lim ? '0 : pcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_clkdiv_ctrl.sv
// Sequences divisor updates for the PWM clock divider: handshake intake,
// boundary-aligned commit, one-cycle divider restart and per-period tick.
module pwm_clkdiv_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned    DW      = DW_DEF,
  parameter logic [DW-1:0]  RST_DIV = DW'(RST_DIV_DEF)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_enable,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [DW-1:0] i_req_divisor,
  output logic [DW-1:0] o_divisor,
  output logic          o_div_rst_n,
  output logic          o_active,
  output logic          o_busy,
  output logic          o_period_tick
);

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [DW-1:0] pend_q;
  logic          rstn_q;
  logic          active_q;
  logic          busy_q;
  logic          cnt_en;
  logic          xfer;
  logic          tick;

  assign cnt_en = (state_q == RUN) || (state_q == WAIT_BND);
  assign o_req_ready = (state_q == IDLE) || (state_q == RUN);
  assign xfer = i_req_valid && o_req_ready;

  pwm_period_counter #(
    .DW(DW)
  ) u_pcnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (!cnt_en),
    .en_i     (cnt_en),
    .divisor_i(div_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      div_q    <= RST_DIV;
      pend_q   <= '0;
      rstn_q   <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) div_q <= i_req_divisor;
          if (i_enable) state_q <= RESYNC;
        end
        RESYNC: begin
          state_q  <= RUN;
          rstn_q   <= 1'b1;
          active_q <= 1'b1;
        end
        RUN: begin
          if (!i_enable) begin
            // Stopped divider: a request can load directly.
            if (xfer) div_q <= i_req_divisor;
            state_q  <= IDLE;
            rstn_q   <= 1'b0;
            active_q <= 1'b0;
          end else if (xfer) begin
            pend_q  <= i_req_divisor;
            busy_q  <= 1'b1;
            state_q <= WAIT_BND;
          end
        end
        WAIT_BND: begin
          if (!i_enable) begin
            div_q    <= pend_q;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
            rstn_q   <= 1'b0;
            active_q <= 1'b0;
          end else if (tick) begin
            div_q    <= pend_q;
            busy_q   <= 1'b0;
            state_q  <= RESYNC;
            rstn_q   <= 1'b0;
            active_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_divisor     = div_q;
  assign o_div_rst_n   = rstn_q;
  assign o_active      = active_q;
  assign o_busy        = busy_q;
  assign o_period_tick = tick;

endmodule

// File: tb/tb_pwm_clkdiv_ctrl.sv
// Bench for pwm_clkdiv_ctrl: table of divisors plus update/abort/reset
// sequences; committed divisors tracked through a scoreboard queue.
module tb_pwm_clkdiv_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_req_valid = 1'b0;
  logic [DW-1:0] i_req_divisor = '0;
  logic          o_req_ready;
  logic [DW-1:0] o_divisor;
  logic          o_div_rst_n;
  logic          o_active;
  logic          o_busy;
  logic          o_period_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] sb[$];
  logic prev_rstn = 1'b0;

  typedef struct {
    logic [DW-1:0] div;
    int            first;
    int            period;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pwm_clkdiv_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .i_enable     (i_enable),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_divisor(i_req_divisor),
    .o_divisor    (o_divisor),
    .o_div_rst_n  (o_div_rst_n),
    .o_active     (o_active),
    .o_busy       (o_busy),
    .o_period_tick(o_period_tick)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  // On each divider restart the newest accepted divisor must be live.
  always @(negedge clk) begin
    if (o_div_rst_n === 1'b1 && prev_rstn === 1'b0 && sb.size() > 0) begin
      chk("sb_div", 32'(o_divisor), 32'(sb[$]));
      sb.delete();
    end
    prev_rstn = o_div_rst_n;
  end

  task automatic send(input logic [DW-1:0] d, output bit ok,
                      output int waits);
    ok = 0;
    waits = 0;
    i_req_valid = 1'b1;
    i_req_divisor = d;
    for (int i = 0; i < 64; i++) begin
      if (o_req_ready) begin
        ok = 1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
      sb.push_back(d);
    end else begin
      chk("send_timeout", 0, 1);
    end
    i_req_valid = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200; i++) begin
      if (o_div_rst_n) return;
      @(negedge clk);
    end
    chk("run_timeout", 0, 1);
  endtask

  task automatic to_tick(output int n);
    n = 0;
    while (!o_period_tick && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!o_period_tick) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    int w;
    int n;
    int t_old;

    tbl[0] = '{16'd0, 0, 1};
    tbl[1] = '{16'd1, 1, 2};
    tbl[2] = '{16'd2, 3, 4};
    tbl[3] = '{16'd3, 5, 6};
    tbl[4] = '{16'd4, 7, 8};
    tbl[5] = '{16'd7, 13, 14};

    repeat (3) @(negedge clk);
    chk("rst_div", 32'(o_divisor), 0);
    chk("rst_rstn", 32'(o_div_rst_n), 0);
    chk("rst_active", 32'(o_active), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_tick", 32'(o_period_tick), 0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(o_req_ready), 1);

    // Enable at reset divisor: one RESYNC cycle, then tick every cycle.
    i_enable = 1'b1;
    @(negedge clk);
    chk("t1_resync_rstn", 32'(o_div_rst_n), 0);
    chk("t1_resync_act", 32'(o_active), 0);
    @(negedge clk);
    chk("t1_run_rstn", 32'(o_div_rst_n), 1);
    chk("t1_run_act", 32'(o_active), 1);
    chk("t1_tick0", 32'(o_period_tick), 1);
    @(negedge clk);
    chk("t1_tick1", 32'(o_period_tick), 1);
    i_enable = 1'b0;
    @(negedge clk);
    chk("t1_stop_rstn", 32'(o_div_rst_n), 0);
    chk("t1_stop_act", 32'(o_active), 0);

    foreach (tbl[k]) begin
      send(tbl[k].div, ok, w);
      chk("tb_idle_load", 32'(o_divisor), 32'(tbl[k].div));
      i_enable = 1'b1;
      @(negedge clk);
      chk("tb_resync", 32'(o_div_rst_n), 0);
      wait_run();
      to_tick(n);
      chk("tb_first", n, tbl[k].first);
      @(negedge clk);
      to_tick(n);
      chk("tb_period", n + 1, tbl[k].period);
      i_enable = 1'b0;
      @(negedge clk);
      chk("tb_off_rstn", 32'(o_div_rst_n), 0);
      chk("tb_off_act", 32'(o_active), 0);
    end

    // Update 3 -> 5 requested at pcnt=1.
    send(16'd3, ok, w);
    i_enable = 1'b1;
    @(negedge clk);
    wait_run();
    @(negedge clk);
    send(16'd5, ok, w);
    chk("t3_busy", 32'(o_busy), 1);
    chk("t3_ready", 32'(o_req_ready), 0);
    n = 0;
    t_old = -100;
    while (o_divisor !== 16'd5 && n < 50) begin
      if (o_period_tick) t_old = cyc;
      @(negedge clk);
      n++;
    end
    chk("t3_upd_delay", n, 4);
    chk("t3_pulse", 32'(o_div_rst_n), 0);
    chk("t3_busy_clr", 32'(o_busy), 0);
    @(negedge clk);
    chk("t3_rstn_back", 32'(o_div_rst_n), 1);
    to_tick(n);
    chk("t3_first", n, 9);
    chk("t3_no_runt", cyc - t_old, 11);
    @(negedge clk);
    to_tick(n);
    chk("t3_period", n + 1, 10);

    // Request at the boundary, then a second one held off until RUN.
    chk("t4_ready", 32'(o_req_ready), 1);
    send(16'd2, ok, w);
    chk("t4_hold_ready", 32'(o_req_ready), 0);
    chk("t4_busy", 32'(o_busy), 1);
    send(16'd7, ok, w);
    chk("t4_hold_waits", w, 11);
    chk("t4_busy2", 32'(o_busy), 1);

    // Drop enable while D=7 is pending.
    i_enable = 1'b0;
    @(negedge clk);
    chk("t5_div", 32'(o_divisor), 7);
    chk("t5_busy", 32'(o_busy), 0);
    chk("t5_rstn", 32'(o_div_rst_n), 0);
    chk("t5_active", 32'(o_active), 0);
    chk("t5_ready", 32'(o_req_ready), 1);
    if (sb.size() == 1) chk("t5_sb", 32'(o_divisor), 32'(sb.pop_front()));
    else chk("t5_sb_size", sb.size(), 1);

    // Async reset in the middle of WAIT_BND.
    i_enable = 1'b1;
    @(negedge clk);
    wait_run();
    chk("t6_div7", 32'(o_divisor), 7);
    send(16'd1, ok, w);
    chk("t6_busy", 32'(o_busy), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_div", 32'(o_divisor), 0);
    chk("t6_rstn", 32'(o_div_rst_n), 0);
    chk("t6_active", 32'(o_active), 0);
    chk("t6_busy_clr", 32'(o_busy), 0);
    chk("t6_tick", 32'(o_period_tick), 0);
    sb.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    wait_run();
    chk("t6_div_after", 32'(o_divisor), 0);
    chk("t6_tick_a", 32'(o_period_tick), 1);
    @(negedge clk);
    chk("t6_tick_b", 32'(o_period_tick), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_clkdiv_ctrl.md
Name: pwm_clkdiv_ctrl

Overview:
Sequences the PWM down-clocking divider, whose output clock has a period of 2*D clk_i cycles for divisor D (D=0 bypasses to clk_i).
- Takes divisor updates through a valid/ready handshake.
- Applies an update only at a divided-clock period boundary, then restarts the divider through a one-cycle synchronous reset pulse, so the PWM clock never emits a runt pulse.
- Mirrors the divider phase and gives downstream PWM logic a per-period tick.

Parameters:
DW, 16, divisor width (must match the divider input width)
RST_DIV, 0, divisor loaded at reset

Ports:
Interface decided: one clock, clk_i; asynchronous active-low reset, rst_ni.
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
i_enable  input  1  run request for the divided clock
i_req_valid  input  1  new-divisor request
o_req_ready  output  1  request can be accepted this cycle
i_req_divisor  input  DW  requested divisor
o_divisor  output  DW  divisor driven to the divider
o_div_rst_n  output  1  divider synchronous reset, active-low
o_active  output  1  divider is running with a settled phase
o_busy  output  1  an update is pending
o_period_tick  output  1  last clk_i cycle of a divided period

Behaviour:
- Reset values: o_divisor=RST_DIV, o_div_rst_n=0, o_active=0, o_busy=0, o_period_tick=0. State is IDLE and pcnt=0.
- pcnt is a DW+1 bit period counter. LIMIT = 2*o_divisor-1, computed at DW+1 bits; LIMIT=0 when o_divisor=0.
- All outputs are registered except o_req_ready and o_period_tick, which are decoded from state and pcnt.
- Handshake: a transfer happens when i_req_valid && o_req_ready. o_req_ready=1 in IDLE and RUN only. A requester holds valid and data stable until ready.
- States:
  - IDLE: o_div_rst_n=0. An accepted request loads o_divisor directly on the next edge. i_enable=1 moves to RESYNC; if a request is accepted in the same cycle, the new divisor is already used.
  - RESYNC, one cycle: o_div_rst_n=0 and pcnt<=0, then RUN. o_active rises on entry to RUN.
  - RUN: o_div_rst_n=1. pcnt increments and wraps to 0 after LIMIT. An accepted request captures the pending register, sets o_busy, and moves to WAIT_BND.
  - WAIT_BND: same counting as RUN. On the cycle where pcnt==LIMIT: o_divisor<=pending, o_busy<=0, go to RESYNC.
- o_period_tick = (RUN or WAIT_BND) && pcnt==LIMIT.
  - With D=0 it fires every cycle.
  - With D=3 it fires every 6th cycle, aligned with the divider's falling output edge.
- i_enable falling:
  - In RUN: go to IDLE next cycle; o_div_rst_n=0 and o_active=0 next cycle.
  - In WAIT_BND: the pending divisor is committed to o_divisor immediately, o_busy clears, and the block goes to IDLE.
- A request equal to the current divisor still goes through WAIT_BND and RESYNC, which costs one restart.
- Worst-case update latency: 2*D_old+1 cycles from acceptance to o_div_rst_n returning high.
- Asynchronous reset mid-update drops the pending divisor.
- Asserting i_enable and i_req_valid in the same RUN cycle is just a normal request.

Decomposition:
- Package pwm_pkg holds:
  - the state enum {IDLE, RESYNC, RUN, WAIT_BND};
  - the DW default constant;
  - the reset-divisor constant.
- One natural sub-module, pwm_period_counter: the pcnt register, the LIMIT computation and the tick decode, with inputs clear, enable and divisor.
- The FSM, handshake and shadow registers stay in the top level.

Test Plan:
1. Reset, then i_enable=1 with RST_DIV=0 -> o_div_rst_n low for exactly 1 cycle (RESYNC), then o_active=1 and o_period_tick high every cycle.
2. In IDLE, request D=4, then enable -> o_divisor=4 before RESYNC; tick every 8 cycles, first tick 7 cycles after RUN entry.
3. Running at D=3, request D=5 at pcnt=1 -> o_busy=1, o_req_ready=0; o_divisor changes on the cycle pcnt==5; 1-cycle reset pulse; ticks then every 10 cycles, never a shorter period.
4. Second valid asserted while in WAIT_BND -> held off (ready=0), accepted on the first RUN cycle after RESYNC.
5. i_enable dropped during WAIT_BND with pending D=7 -> IDLE next cycle, o_divisor=7, o_busy=0, o_div_rst_n=0.
6. Async rst_ni asserted mid-WAIT_BND, between clock edges -> outputs take reset values immediately; pending divisor lost; o_divisor=RST_DIV.
